// File: rtl/line_buffer_ctrl_pkg.sv
// Shared filter-path definitions for the line buffer controller: sequencer
// states, counter width and default picture geometry.
package line_buffer_ctrl_pkg;

   localparam int CNT_W          = 9;
   localparam int TMR_W          = 16;
   localparam int PIC_WIDTH_DEF  = 320;
   localparam int PIC_HEIGHT_DEF = 240;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_FILL      = 3'd3,
      ST_FLUSH     = 3'd4,
      ST_DONE      = 3'd5
   } lbc_state_e;

endpackage

// File: rtl/line_buffer_ctrl_pos_cnt.sv
// Column/row position counter. Tracks the position the next pixel will take
// and publishes the position of the last accepted pixel.
module lbc_pos_cnt
   import line_buffer_ctrl_pkg::*;
#(
   parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
   parameter int PIC_HEIGHT = PIC_HEIGHT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] col_o,
   output logic [CNT_W-1:0] row_o,
   output logic             last_o,
   output logic             win_row_o
);

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(PIC_WIDTH - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(PIC_HEIGHT - 1);

   logic [CNT_W-1:0] pos_col_q, pos_col_d;
   logic [CNT_W-1:0] pos_row_q, pos_row_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;

   always_comb begin
      pos_col_d = pos_col_q;
      pos_row_d = pos_row_q;
      col_d     = col_q;
      row_d     = row_q;
      if (clr_i) begin
         pos_col_d = '0;
         pos_row_d = '0;
         col_d     = '0;
         row_d     = '0;
      end else if (inc_i) begin
         col_d = pos_col_q;
         row_d = pos_row_q;
         if (pos_col_q == COL_LAST) begin
            pos_col_d = '0;
            // Wrapping the row after the last pixel keeps every value in range.
            pos_row_d = (pos_row_q == ROW_LAST) ? '0 : pos_row_q + 1'b1;
         end else begin
            pos_col_d = pos_col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_col_q <= '0;
         pos_row_q <= '0;
         col_q     <= '0;
         row_q     <= '0;
      end else begin
         pos_col_q <= pos_col_d;
         pos_row_q <= pos_row_d;
         col_q     <= col_d;
         row_q     <= row_d;
      end
   end

   assign col_o     = col_q;
   assign row_o     = row_q;
   assign last_o    = (pos_col_q == COL_LAST) && (pos_row_q == ROW_LAST);
   assign win_row_o = (pos_row_q >= CNT_W'(2));

endmodule

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the three-FIFO line buffer: FIFO reset, pixel gating,
// window-valid and end-of-frame drain. Drain is built only with LBC_FLUSH_EN.
module line_buffer_ctrl
   import line_buffer_ctrl_pkg::*;
#(
   parameter int PIC_WIDTH   = PIC_WIDTH_DEF,
   parameter int PIC_HEIGHT  = PIC_HEIGHT_DEF,
   parameter int RST_CYCLES  = 4,
   parameter int BUSY_GUARD  = 8,
   parameter int FLUSH_LINES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start_i,
   input  logic             valid_in_i,
   output logic             pix_ready_o,
   input  logic             fifo_rst_busy_i,
   output logic             rst_fifo_o,
   output logic             lb_valid_o,
   output logic             rd_en_all_o,
   output logic             win_valid_o,
   output logic [CNT_W-1:0] col_cnt_o,
   output logic [CNT_W-1:0] row_cnt_o,
   output logic             frame_done_o,
   output logic             pix_drop_o
);

   localparam logic [TMR_W-1:0] RST_LAST   = TMR_W'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
   localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'((BUSY_GUARD > 0) ? BUSY_GUARD - 1 : 0);
   localparam logic [TMR_W-1:0] FLUSH_LAST =
      TMR_W'((FLUSH_LINES * PIC_WIDTH > 0) ? FLUSH_LINES * PIC_WIDTH - 1 : 0);

   lbc_state_e       state_q;
   logic [TMR_W-1:0] tmr_q;
   logic             rst_fifo_q;
   logic             pix_ready_q;
   logic             rd_en_all_q;
   logic             frame_done_q;
   logic             win_valid_q;
   logic             pix_drop_q;
   logic             lb_valid;
   logic             last_pix;
   logic             win_row;
   logic             drop_state;

   assign lb_valid = valid_in_i && pix_ready_q;

   lbc_pos_cnt #(
      .PIC_WIDTH  (PIC_WIDTH),
      .PIC_HEIGHT (PIC_HEIGHT)
   ) u_pos_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (frame_start_i || (state_q == ST_RESET)),
      .inc_i     (lb_valid),
      .col_o     (col_cnt_o),
      .row_o     (row_cnt_o),
      .last_o    (last_pix),
      .win_row_o (win_row)
   );

   // frame_start wins over every state, so a frame can always be restarted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tmr_q        <= '0;
         rst_fifo_q   <= 1'b0;
         pix_ready_q  <= 1'b0;
         rd_en_all_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (frame_start_i) begin
            state_q     <= ST_RESET;
            tmr_q       <= '0;
            rst_fifo_q  <= 1'b0;
            pix_ready_q <= 1'b0;
            rd_en_all_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: rst_fifo_q <= 1'b1;
               ST_RESET: begin
                  if (tmr_q == RST_LAST) begin
                     state_q    <= ST_WAIT_BUSY;
                     tmr_q      <= '0;
                     rst_fifo_q <= 1'b1;
                  end else begin
                     tmr_q <= tmr_q + 1'b1;
                  end
               end
               ST_WAIT_BUSY: begin
                  if (tmr_q < GUARD_LAST) begin
                     tmr_q <= tmr_q + 1'b1;
                  end else if (!fifo_rst_busy_i) begin
                     state_q     <= ST_FILL;
                     pix_ready_q <= 1'b1;
                  end
               end
               ST_FILL: begin
                  if (lb_valid && last_pix) begin
                     pix_ready_q <= 1'b0;
                     tmr_q       <= '0;
`ifdef LBC_FLUSH_EN
                     state_q     <= ST_FLUSH;
                     rd_en_all_q <= 1'b1;
`else
                     state_q      <= ST_DONE;
                     frame_done_q <= 1'b1;
`endif
                  end
               end
               ST_FLUSH: begin
                  if (tmr_q == FLUSH_LAST) begin
                     state_q      <= ST_DONE;
                     rd_en_all_q  <= 1'b0;
                     frame_done_q <= 1'b1;
                  end else begin
                     tmr_q <= tmr_q + 1'b1;
                  end
               end
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign drop_state = (state_q == ST_RESET) || (state_q == ST_WAIT_BUSY) ||
                       (state_q == ST_FLUSH) || (state_q == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid_q <= 1'b0;
         pix_drop_q  <= 1'b0;
      end else begin
         win_valid_q <= (lb_valid && win_row) || rd_en_all_q;
         pix_drop_q  <= valid_in_i && !pix_ready_q && drop_state;
      end
   end

   assign pix_ready_o  = pix_ready_q;
   assign rst_fifo_o   = rst_fifo_q;
   assign lb_valid_o   = lb_valid;
   assign win_valid_o  = win_valid_q;
   assign frame_done_o = frame_done_q;
   assign pix_drop_o   = pix_drop_q;
`ifdef LBC_FLUSH_EN
   assign rd_en_all_o  = rd_en_all_q;
`else
   assign rd_en_all_o  = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on a 4x3 picture; covers both the
// default build and LBC_FLUSH_EN.
module tb_line_buffer_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_start;
   logic       valid_in;
   logic       fifo_rst_busy;
   logic       pix_ready;
   logic       rst_fifo;
   logic       lb_valid;
   logic       rd_en_all;
   logic       win_valid;
   logic [8:0] col_cnt;
   logic [8:0] row_cnt;
   logic       frame_done;
   logic       pix_drop;

   int n_tests = 0;
   int n_fail  = 0;
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   line_buffer_ctrl #(
      .PIC_WIDTH   (4),
      .PIC_HEIGHT  (3),
      .RST_CYCLES  (4),
      .BUSY_GUARD  (8),
      .FLUSH_LINES (1)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .frame_start_i   (frame_start),
      .valid_in_i      (valid_in),
      .pix_ready_o     (pix_ready),
      .fifo_rst_busy_i (fifo_rst_busy),
      .rst_fifo_o      (rst_fifo),
      .lb_valid_o      (lb_valid),
      .rd_en_all_o     (rd_en_all),
      .win_valid_o     (win_valid),
      .col_cnt_o       (col_cnt),
      .row_cnt_o       (row_cnt),
      .frame_done_o    (frame_done),
      .pix_drop_o      (pix_drop)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses frame_start and returns the number of cycles rst_fifo stayed low.
   task automatic start_frame(output int n_low);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      n_low = 0;
      while (rst_fifo == 1'b0 && n_low < 50) begin
         n_low++;
         step();
      end
   endtask

   task automatic wait_ready(output int n, output logic saw_done);
      n = 0;
      saw_done = 1'b0;
      while (!pix_ready && n < 60) begin
         step();
         n++;
         if (frame_done) saw_done = 1'b1;
      end
   endtask

   initial begin
      int   n;
      logic saw;
      logic [17:0] exp_pos;
      logic [4:0]  drop_pat;

      rst_n = 1'b0;
      frame_start = 1'b0;
      valid_in = 1'b0;
      fifo_rst_busy = 1'b0;
      step();
      step();
      check("rst_rst_fifo", 32'(rst_fifo), 32'd0);
      check("rst_pix_ready", 32'(pix_ready), 32'd0);
      check("rst_outs", 32'({lb_valid, rd_en_all, win_valid, frame_done, pix_drop}), 32'd0);
      check("rst_cnt", 32'({row_cnt, col_cnt}), 32'd0);

      rst_n = 1'b1;
      step();
      check("rel_rst_fifo", 32'(rst_fifo), 32'd1);

      // Frame 1: guard-limited wait, full 4x3 frame.
      start_frame(n);
      check("a_rst_low_cycles", 32'(n), 32'd4);
      wait_ready(n, saw);
      check("a_ready_delay", 32'(n), 32'd8);

      for (int i = 0; i < 12; i++) exp_q.push_back({9'(i / 4), 9'(i % 4)});
      valid_in = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("a_lb_valid", 32'(lb_valid), 32'd1);
         step();
         exp_pos = exp_q.pop_front();
         check("a_pos", 32'({row_cnt, col_cnt}), 32'(exp_pos));
         check("a_win", 32'(win_valid), 32'(i >= 8));
      end
      valid_in = 1'b0;
      check("a_ready_off", 32'(pix_ready), 32'd0);
`ifdef LBC_FLUSH_EN
      check("a_rd_en_start", 32'(rd_en_all), 32'd1);
      n = 0;
      while (rd_en_all && n < 50) begin
         n++;
         step();
         check("a_flush_win", 32'(win_valid), 32'd1);
      end
      check("a_rd_en_cycles", 32'(n), 32'd4);
      check("a_done", 32'(frame_done), 32'd1);
`else
      check("a_rd_en_off", 32'(rd_en_all), 32'd0);
      check("a_done", 32'(frame_done), 32'd1);
`endif
      step();
      check("a_done_pulse", 32'(frame_done), 32'd0);
      check("a_win_end", 32'(win_valid), 32'd0);

      // Frame 2: busy held high for 20 cycles past the reset window.
      fifo_rst_busy = 1'b1;
      start_frame(n);
      check("b_rst_low_cycles", 32'(n), 32'd4);
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (pix_ready) saw = 1'b1;
      end
      check("b_ready_held", 32'(saw), 32'd0);
      fifo_rst_busy = 1'b0;
      step();
      check("b_ready_after_busy", 32'(pix_ready), 32'd1);

      // Abort after 6 pixels.
      valid_in = 1'b1;
      for (int i = 0; i < 6; i++) step();
      valid_in = 1'b0;
      check("c_pos_before", 32'({row_cnt, col_cnt}), 32'({9'd1, 9'd1}));
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("c_cnt_clear", 32'({row_cnt, col_cnt}), 32'd0);
      check("c_ready_off", 32'(pix_ready), 32'd0);
      n = 0;
      while (rst_fifo == 1'b0 && n < 50) begin
         n++;
         if (frame_done) saw = 1'b1;
         step();
      end
      check("c_rst_low_cycles", 32'(n), 32'd4);
      wait_ready(n, saw);
      check("c_ready_delay", 32'(n), 32'd8);
      check("c_no_done", 32'(saw), 32'd0);

      // Pixels offered during WAIT_BUSY are dropped, one pulse per cycle.
      start_frame(n);
      check("d_rst_low_cycles", 32'(n), 32'd4);
      drop_pat = 5'b01011;
      n = 0;
      for (int k = 0; k < 5; k++) begin
         valid_in = drop_pat[k];
         #1;
         check("d_lb_valid", 32'(lb_valid), 32'd0);
         step();
         check("d_pix_drop", 32'(pix_drop), 32'(drop_pat[k]));
         if (pix_drop) n++;
      end
      valid_in = 1'b0;
      check("d_drop_count", 32'(n), 32'd3);

      // Asynchronous reset mid-frame.
      wait_ready(n, saw);
      check("e_ready", 32'(pix_ready), 32'd1);
      valid_in = 1'b1;
      step();
      step();
      valid_in = 1'b0;
      check("e_pos", 32'({row_cnt, col_cnt}), 32'({9'd0, 9'd1}));
      rst_n = 1'b0;
      #1;
      check("e_rst_fifo", 32'(rst_fifo), 32'd0);
      check("e_ready_off", 32'(pix_ready), 32'd0);
      check("e_cnt_clear", 32'({row_cnt, col_cnt}), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("e_rel_rst_fifo", 32'(rst_fifo), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
